// File: rtl/bus_dev_port.sv
// Bus device port: host-side TX FIFO feeding an arbiter, arbiter-side RX FIFO feeding the host.
// Optional destination-address filter on the RX side, enabled by defining BUS_DEV_PORT_FILTER_EN.
module bus_dev_port #(
    parameter int          pckg_sz   = 16,
    parameter int          depth     = 8,
    parameter logic [7:0]  dev_id    = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_empty,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               tx_ovf,
    output logic               rx_ovf
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);
`ifdef BUS_DEV_PORT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [AW-1:0]      tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0]      tx_cnt, rx_cnt;
    logic               tx_we, tx_re, rx_we, rx_re;
    logic               tx_is_full, rx_is_full;
    logic               addr_hit, rx_accept;

    assign tx_is_full = (tx_cnt == FULL_CNT);
    assign rx_is_full = (rx_cnt == FULL_CNT);

    // A pop frees the head slot at the same edge, so a write into a full FIFO
    // lands in the slot being vacated (wptr == rptr when full).
    assign tx_re = pop && (tx_cnt != '0);
    assign tx_we = tx_wr && (!tx_is_full || tx_re);

    assign addr_hit  = (D_push[pckg_sz-1 -: 8] == dev_id) ||
                       (D_push[pckg_sz-1 -: 8] == broadcast);
    assign rx_accept = push && (!FILTER || addr_hit);
    assign rx_re     = rx_rd && (rx_cnt != '0);
    assign rx_we     = rx_accept && (!rx_is_full || rx_re);

    assign pndng    = (tx_cnt != '0);
    assign D_pop    = pndng ? tx_mem[tx_rptr] : '0;
    assign tx_full  = tx_is_full;
    assign rx_empty = (rx_cnt == '0);
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rptr];

    always_ff @(posedge clk) begin
        if (tx_we) tx_mem[tx_wptr] <= tx_data;
        if (rx_we) rx_mem[rx_wptr] <= D_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
            tx_ovf  <= 1'b0;
        end else begin
            if (tx_we) tx_wptr <= tx_wptr + AW'(1);
            if (tx_re) tx_rptr <= tx_rptr + AW'(1);
            case ({tx_we, tx_re})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
            if (tx_wr && !tx_we) tx_ovf <= 1'b1;
        end
    end

    // Filtered-out packets never reach rx_we logic, so they cannot raise rx_ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
            rx_ovf  <= 1'b0;
        end else begin
            if (rx_we) rx_wptr <= rx_wptr + AW'(1);
            if (rx_re) rx_rptr <= rx_rptr + AW'(1);
            case ({rx_we, rx_re})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
            if (rx_accept && !rx_we) rx_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_dev_port.sv
// Directed bench for bus_dev_port: TX/RX FIFO ordering, full/overflow edges, filter, async reset.
module tb_bus_dev_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_wr = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_full;
    logic        rx_rd = 1'b0;
    logic [15:0] rx_data;
    logic        rx_empty;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [15:0] D_push = '0;
    logic        tx_ovf, rx_ovf;

    int n_cmp = 0;
    int n_fail = 0;

    bus_dev_port #(.pckg_sz(16), .depth(8), .dev_id(8'h02), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .pndng(pndng),
        .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
        .tx_ovf(tx_ovf), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_cmp++; if (pndng !== 1'b0)    begin n_fail++; $display("FAIL reset_pndng got=%b exp=0", pndng); end
        n_cmp++; if (D_pop !== 16'h0)   begin n_fail++; $display("FAIL reset_d_pop got=%h exp=0000", D_pop); end
        n_cmp++; if (tx_full !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); end
        n_cmp++; if (rx_data !== 16'h0) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
        n_cmp++; if (tx_ovf !== 1'b0 || rx_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b%b exp=00", tx_ovf, rx_ovf); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_tx();
        tx_wr = 1'b1; tx_data = 16'h0312;
        tick();
        tx_wr = 1'b0;
        n_cmp++; if (pndng !== 1'b1)     begin n_fail++; $display("FAIL single_pndng got=%b exp=1", pndng); end
        n_cmp++; if (D_pop !== 16'h0312) begin n_fail++; $display("FAIL single_d_pop got=%h exp=0312", D_pop); end
        pop = 1'b1;
        tick();
        n_cmp++; if (pndng !== 1'b0)  begin n_fail++; $display("FAIL single_pop_pndng got=%b exp=0", pndng); end
        n_cmp++; if (D_pop !== 16'h0) begin n_fail++; $display("FAIL single_pop_d_pop got=%h exp=0000", D_pop); end
        // pop still high on empty FIFO, together with a write: pop ignored, write stored
        tx_wr = 1'b1; tx_data = 16'h0456;
        tick();
        tx_wr = 1'b0; pop = 1'b0;
        n_cmp++; if (pndng !== 1'b1 || D_pop !== 16'h0456) begin n_fail++; $display("FAIL empty_wr_pop got=%b/%h exp=1/0456", pndng, D_pop); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL empty_wr_pop_drain got=%b exp=0", pndng); end
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 9; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0100 + 16'(i);
            tick();
            n_cmp++; if (tx_full !== (i >= 7)) begin n_fail++; $display("FAIL tx_full_fill%0d got=%b exp=%b", i, tx_full, (i >= 7)); end
        end
        tx_wr = 1'b0;
        n_cmp++; if (tx_ovf !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_set got=%b exp=1", tx_ovf); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (D_pop !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL tx_full_order%0d got=%h exp=%h", i, D_pop, 16'h0100 + 16'(i)); end
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        n_cmp++; if (pndng !== 1'b0 || tx_ovf !== 1'b1) begin n_fail++; $display("FAIL tx_drained got=%b/%b exp=0/1", pndng, tx_ovf); end
    endtask

    task automatic test_full_wr_pop();
        logic [15:0] exp_q[$];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0200 + 16'(i);
            exp_q.push_back(16'h0200 + 16'(i));
            tick();
        end
        tx_wr = 1'b1; pop = 1'b1; tx_data = 16'h02AA;
        void'(exp_q.pop_front());
        exp_q.push_back(16'h02AA);
        tick();
        tx_wr = 1'b0; pop = 1'b0;
        n_cmp++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL wr_pop_full got=%b exp=1", tx_full); end
        n_cmp++; if (tx_ovf !== 1'b0)  begin n_fail++; $display("FAIL wr_pop_ovf got=%b exp=0", tx_ovf); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (D_pop !== exp_q[i]) begin n_fail++; $display("FAIL wr_pop_order%0d got=%h exp=%h", i, D_pop, exp_q[i]); end
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        n_cmp++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL wr_pop_drained got=%b exp=0", pndng); end
    endtask

    task automatic test_filter();
        logic [15:0] pkts[3] = '{16'h02AA, 16'h05BB, 16'hFFCC};
        logic [15:0] exp_q[$];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; D_push = pkts[i];
`ifdef BUS_DEV_PORT_FILTER_EN
            if (pkts[i][15:8] == 8'h02 || pkts[i][15:8] == 8'hFF) exp_q.push_back(pkts[i]);
`else
            exp_q.push_back(pkts[i]);
`endif
            tick();
        end
        push = 1'b0;
        n_cmp++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL filter_ovf got=%b exp=0", rx_ovf); end
        while (exp_q.size() > 0) begin
            n_cmp++; if (rx_data !== exp_q[0]) begin n_fail++; $display("FAIL filter_data got=%h exp=%h", rx_data, exp_q[0]); end
            void'(exp_q.pop_front());
            rx_rd = 1'b1;
            tick();
            rx_rd = 1'b0;
        end
        n_cmp++; if (rx_empty !== 1'b1 || rx_data !== 16'h0) begin n_fail++; $display("FAIL filter_empty got=%b/%h exp=1/0000", rx_empty, rx_data); end
        // read while empty is ignored
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        n_cmp++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rx_rd_empty got=%b exp=1", rx_empty); end
    endtask

    task automatic test_rx_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i);
            rx_rd = (i > 0);
            if (i > 0) begin
                n_cmp++; if (rx_data !== 16'h0200 + 16'(i - 1)) begin n_fail++; $display("FAIL rx_wrap%0d got=%h exp=%h", i, rx_data, 16'h0200 + 16'(i - 1)); end
            end
            tick();
        end
        push = 1'b0; rx_rd = 1'b1;
        n_cmp++; if (rx_data !== 16'h0213) begin n_fail++; $display("FAIL rx_wrap_last got=%h exp=0213", rx_data); end
        tick();
        rx_rd = 1'b0;
        n_cmp++; if (rx_empty !== 1'b1 || rx_ovf !== 1'b0) begin n_fail++; $display("FAIL rx_wrap_end got=%b/%b exp=1/0", rx_empty, rx_ovf); end
    endtask

    task automatic test_rx_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i);
            tick();
        end
        D_push = 16'h02EE;
        tick();
        n_cmp++; if (rx_ovf !== 1'b1) begin n_fail++; $display("FAIL rx_ovf_set got=%b exp=1", rx_ovf); end
        D_push = 16'h02DD; rx_rd = 1'b1;
        tick();
        push = 1'b0; rx_rd = 1'b0;
        for (int i = 1; i < 9; i++) begin
            logic [15:0] e;
            e = (i < 8) ? 16'h0200 + 16'(i) : 16'h02DD;
            n_cmp++; if (rx_data !== e) begin n_fail++; $display("FAIL rx_full_order%0d got=%h exp=%h", i, rx_data, e); end
            rx_rd = 1'b1;
            tick();
            rx_rd = 1'b0;
        end
        n_cmp++; if (rx_empty !== 1'b1 || rx_ovf !== 1'b1) begin n_fail++; $display("FAIL rx_full_end got=%b/%b exp=1/1", rx_empty, rx_ovf); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0700 + 16'(i);
            push = (i < 2); D_push = 16'h0280 + 16'(i);
            tick();
        end
        tx_wr = 1'b0; push = 1'b0;
        n_cmp++; if (pndng !== 1'b1 || rx_empty !== 1'b0) begin n_fail++; $display("FAIL mid_pre got=%b/%b exp=1/0", pndng, rx_empty); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (pndng !== 1'b0 || D_pop !== 16'h0) begin n_fail++; $display("FAIL mid_tx got=%b/%h exp=0/0000", pndng, D_pop); end
        n_cmp++; if (rx_empty !== 1'b1 || rx_data !== 16'h0) begin n_fail++; $display("FAIL mid_rx got=%b/%h exp=1/0000", rx_empty, rx_data); end
        n_cmp++; if (tx_ovf !== 1'b0 || rx_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got=%b%b exp=00", tx_ovf, rx_ovf); end
        tick();
        reset = 1'b0;
        tx_wr = 1'b1; tx_data = 16'h0999;
        push = 1'b1; D_push = 16'h02A5;
        tick();
        tx_wr = 1'b0; push = 1'b0;
        n_cmp++; if (pndng !== 1'b1 || D_pop !== 16'h0999) begin n_fail++; $display("FAIL post_tx got=%b/%h exp=1/0999", pndng, D_pop); end
        n_cmp++; if (rx_empty !== 1'b0 || rx_data !== 16'h02A5) begin n_fail++; $display("FAIL post_rx got=%b/%h exp=0/02A5", rx_empty, rx_data); end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_tx();
        test_tx_full();
        test_full_wr_pop();
        test_filter();
        test_rx_wrap();
        test_rx_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
